// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the commit-stage trap sequencer.
// Holds the FSM state enum, event types, interrupt codes and the trap pack struct.
package trap_sequencer_pkg;

    localparam int TRAP_XLEN = 64;

    // Standard machine/supervisor interrupt cause codes
    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_SEI = 9;
    localparam int IRQ_SSI = 1;
    localparam int IRQ_STI = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } trap_seq_state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_IRQ,
        EV_MRET
    } trap_event_t;

    typedef struct packed {
        logic [TRAP_XLEN-1:0] cause;
        logic [TRAP_XLEN-1:0] epc;
        logic [TRAP_XLEN-1:0] tval;
    } trap_pack_t;

endpackage

// File: rtl/trap_sequencer_irq_prio_sel.sv
// Combinational interrupt priority encoder: architectural fixed order first,
// then the lowest pending index among the remaining lines.
module irq_prio_sel
    import trap_sequencer_pkg::*;
#(
    parameter int NIRQ   = 16,
    parameter int CODE_W = 6
) (
    input  logic [NIRQ-1:0]   pending,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    // Pad to at least 12 lines so the fixed-order codes are always indexable
    localparam int PW = (NIRQ > 12) ? NIRQ : 12;

    logic [PW-1:0]     padded;
    logic [CODE_W-1:0] lowest;

    assign padded = PW'(pending);
    assign any    = |pending;

    always_comb begin
        lowest = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (padded[i]) begin
                lowest = CODE_W'(i);
            end
        end
    end

    always_comb begin
        code = lowest;
        if (padded[IRQ_MEI]) begin
            code = CODE_W'(IRQ_MEI);
        end else if (padded[IRQ_MSI]) begin
            code = CODE_W'(IRQ_MSI);
        end else if (padded[IRQ_MTI]) begin
            code = CODE_W'(IRQ_MTI);
        end else if (padded[IRQ_SEI]) begin
            code = CODE_W'(IRQ_SEI);
        end else if (padded[IRQ_SSI]) begin
            code = CODE_W'(IRQ_SSI);
        end else if (padded[IRQ_STI]) begin
            code = CODE_W'(IRQ_STI);
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Commit-stage sequencer for exceptions, interrupts and mret: flush, drain,
// one-cycle pulse to the privilege unit, then a handshaked front-end redirect.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN   = TRAP_XLEN,
    parameter int CODE_W = 6,
    parameter int NIRQ   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_exc_vld,
    input  logic [CODE_W-1:0] i_exc_code,
    input  logic [XLEN-1:0]   i_exc_epc,
    input  logic [XLEN-1:0]   i_exc_tval,
    input  logic              i_mret_vld,
    input  logic [XLEN-1:0]   i_mepc,
    input  logic [NIRQ-1:0]   i_irq_pending,
    input  logic              i_global_ie,
    input  logic              i_irq_allow,
    input  logic [XLEN-1:0]   i_next_pc,
    input  logic              i_drained,
    input  logic [XLEN-1:0]   i_tvec,
    input  logic              i_vectored,
    input  logic              i_redirect_rdy,
    output logic              o_commit_block,
    output logic              o_flush,
    output logic              o_trap_vld,
    output logic [XLEN-1:0]   o_trap_cause,
    output logic [XLEN-1:0]   o_trap_epc,
    output logic [XLEN-1:0]   o_trap_tval,
    output logic              o_mret,
    output logic              o_redirect_vld,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic              o_busy
);

    trap_seq_state_t   state_q;
    trap_seq_state_t   state_d;
    trap_event_t       ev_q;
    trap_event_t       ev_sel;

    logic [CODE_W-1:0] irq_code;
    logic              irq_any;
    logic              irq_take;

    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   tval_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   vec_off;

    trap_pack_t        trap_out;

    irq_prio_sel #(
        .NIRQ   (NIRQ),
        .CODE_W (CODE_W)
    ) u_irq_prio_sel (
        .pending (i_irq_pending),
        .code    (irq_code),
        .any     (irq_any)
    );

    assign irq_take = i_global_ie & i_irq_allow & irq_any;

    // Exception beats interrupt beats mret; a same-cycle mret is simply dropped
    always_comb begin
        ev_sel = EV_NONE;
        if (i_exc_vld) begin
            ev_sel = EV_EXC;
        end else if (irq_take) begin
            ev_sel = EV_IRQ;
        end else if (i_mret_vld) begin
            ev_sel = EV_MRET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ev_q    <= EV_NONE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            mepc_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && ev_sel != EV_NONE) begin
                ev_q <= ev_sel;
                unique case (ev_sel)
                    EV_EXC: begin
                        cause_q <= XLEN'(i_exc_code);
                        epc_q   <= i_exc_epc;
                        tval_q  <= i_exc_tval;
                    end
                    EV_IRQ: begin
                        cause_q <= {1'b1, (XLEN-1)'(irq_code)};
                        epc_q   <= i_next_pc;
                        tval_q  <= '0;
                    end
                    EV_MRET: begin
                        mepc_q  <= i_mepc;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Vector offset uses the captured code; the base is read live so it
    // reflects any mtvec update performed by the privilege unit on the pulse
    assign vec_off = XLEN'(cause_q[CODE_W-1:0]) << 2;

    always_comb begin
        state_d        = state_q;
        o_commit_block = 1'b0;
        o_flush        = 1'b0;
        o_trap_vld     = 1'b0;
        o_mret         = 1'b0;
        o_redirect_vld = 1'b0;
        o_redirect_pc  = '0;
        trap_out       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ev_sel != EV_NONE) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                o_commit_block = 1'b1;
                o_flush        = 1'b1;
                state_d        = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_commit_block = 1'b1;
                if (i_drained) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                o_commit_block = 1'b1;
                if (ev_q == EV_MRET) begin
                    o_mret = 1'b1;
                end else begin
                    o_trap_vld     = 1'b1;
                    trap_out.cause = TRAP_XLEN'(cause_q);
                    trap_out.epc   = TRAP_XLEN'(epc_q);
                    trap_out.tval  = TRAP_XLEN'(tval_q);
                end
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                o_commit_block = 1'b1;
                o_redirect_vld = 1'b1;
                if (ev_q == EV_MRET) begin
                    o_redirect_pc = mepc_q;
                end else if (ev_q == EV_IRQ && i_vectored) begin
                    o_redirect_pc = i_tvec + vec_off;
                end else begin
                    o_redirect_pc = i_tvec;
                end
                if (i_redirect_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_trap_cause = XLEN'(trap_out.cause);
    assign o_trap_epc   = XLEN'(trap_out.epc);
    assign o_trap_tval  = XLEN'(trap_out.tval);
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer: exceptions, interrupts,
// mret, priority, drain/redirect stalls and asynchronous reset mid-sequence.
module tb_trap_sequencer;

    logic        clk;
    logic        rst;
    logic        i_exc_vld;
    logic [5:0]  i_exc_code;
    logic [63:0] i_exc_epc;
    logic [63:0] i_exc_tval;
    logic        i_mret_vld;
    logic [63:0] i_mepc;
    logic [15:0] i_irq_pending;
    logic        i_global_ie;
    logic        i_irq_allow;
    logic [63:0] i_next_pc;
    logic        i_drained;
    logic [63:0] i_tvec;
    logic        i_vectored;
    logic        i_redirect_rdy;
    logic        o_commit_block;
    logic        o_flush;
    logic        o_trap_vld;
    logic [63:0] o_trap_cause;
    logic [63:0] o_trap_epc;
    logic [63:0] o_trap_tval;
    logic        o_mret;
    logic        o_redirect_vld;
    logic [63:0] o_redirect_pc;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    trap_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_exc_vld      (i_exc_vld),
        .i_exc_code     (i_exc_code),
        .i_exc_epc      (i_exc_epc),
        .i_exc_tval     (i_exc_tval),
        .i_mret_vld     (i_mret_vld),
        .i_mepc         (i_mepc),
        .i_irq_pending  (i_irq_pending),
        .i_global_ie    (i_global_ie),
        .i_irq_allow    (i_irq_allow),
        .i_next_pc      (i_next_pc),
        .i_drained      (i_drained),
        .i_tvec         (i_tvec),
        .i_vectored     (i_vectored),
        .i_redirect_rdy (i_redirect_rdy),
        .o_commit_block (o_commit_block),
        .o_flush        (o_flush),
        .o_trap_vld     (o_trap_vld),
        .o_trap_cause   (o_trap_cause),
        .o_trap_epc     (o_trap_epc),
        .o_trap_tval    (o_trap_tval),
        .o_mret         (o_mret),
        .o_redirect_vld (o_redirect_vld),
        .o_redirect_pc  (o_redirect_pc),
        .o_busy         (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Commit is blocked, so the ROB must not present new events meanwhile
    always @(negedge clk) begin
        if (o_commit_block) begin
            n_checks++;
            if (i_exc_vld || i_mret_vld) begin
                n_fail++;
                $display("[TB] FAIL event_while_blocked: exc=%b mret=%b required 0", i_exc_vld, i_mret_vld);
            end
        end
    end

    task automatic set_defaults();
        i_exc_vld      = 1'b0;
        i_exc_code     = '0;
        i_exc_epc      = '0;
        i_exc_tval     = '0;
        i_mret_vld     = 1'b0;
        i_mepc         = '0;
        i_irq_pending  = '0;
        i_global_ie    = 1'b1;
        i_irq_allow    = 1'b1;
        i_next_pc      = '0;
        i_drained      = 1'b1;
        i_tvec         = '0;
        i_vectored     = 1'b0;
        i_redirect_rdy = 1'b1;
    endtask

    // Let the DUT sample the event at the coming edge, then withdraw it
    task automatic present_event();
        @(posedge clk);
        #1;
        i_exc_vld     = 1'b0;
        i_mret_vld    = 1'b0;
        i_irq_pending = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_defaults();
        #12;
        n_checks++;
        if ({o_commit_block, o_flush, o_trap_vld, o_mret, o_redirect_vld, o_busy} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000",
                     {o_commit_block, o_flush, o_trap_vld, o_mret, o_redirect_vld, o_busy});
        end
        n_checks++;
        if ((o_trap_cause | o_trap_epc | o_trap_tval | o_redirect_pc) !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h required 0",
                     o_trap_cause | o_trap_epc | o_trap_tval | o_redirect_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal_instr();
        @(negedge clk);
        i_exc_vld  = 1'b1;
        i_exc_code = 6'd2;
        i_exc_epc  = 64'h8000_0010;
        i_exc_tval = 64'hDEAD;
        i_tvec     = 64'h8000_1000;
        i_vectored = 1'b1;
        present_event();
        @(negedge clk);
        n_checks++;
        if ({o_flush, o_commit_block, o_trap_vld, o_busy} !== 4'b1101) begin
            n_fail++;
            $display("[TB] FAIL illegal_flush: got %b required 1101", {o_flush, o_commit_block, o_trap_vld, o_busy});
        end
        @(negedge clk);
        n_checks++;
        if ({o_flush, o_commit_block, o_trap_vld, o_redirect_vld} !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL illegal_drain: got %b required 0100", {o_flush, o_commit_block, o_trap_vld, o_redirect_vld});
        end
        @(negedge clk);
        n_checks++;
        if ({o_trap_vld, o_mret} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL illegal_pulse: got %b required 10", {o_trap_vld, o_mret});
        end
        n_checks++;
        if (o_trap_cause !== 64'h2) begin
            n_fail++;
            $display("[TB] FAIL illegal_cause: got %h required 2", o_trap_cause);
        end
        n_checks++;
        if (o_trap_epc !== 64'h8000_0010) begin
            n_fail++;
            $display("[TB] FAIL illegal_epc: got %h required 80000010", o_trap_epc);
        end
        n_checks++;
        if (o_trap_tval !== 64'hDEAD) begin
            n_fail++;
            $display("[TB] FAIL illegal_tval: got %h required dead", o_trap_tval);
        end
        @(negedge clk);
        n_checks++;
        if ({o_redirect_vld, o_trap_vld} !== 2'b10 || o_trap_cause !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL illegal_redir_vld: vld/trap %b cause %h required 10 and 0",
                     {o_redirect_vld, o_trap_vld}, o_trap_cause);
        end
        n_checks++;
        if (o_redirect_pc !== 64'h8000_1000) begin
            n_fail++;
            $display("[TB] FAIL illegal_redir_pc: got %h required 80001000", o_redirect_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({o_redirect_vld, o_busy, o_commit_block} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL illegal_idle: got %b required 000", {o_redirect_vld, o_busy, o_commit_block});
        end
        set_defaults();
    endtask

    task automatic test_timer_irq_vectored();
        @(negedge clk);
        i_irq_pending = 16'h0080;
        i_next_pc     = 64'h100;
        i_tvec        = 64'h2000;
        i_vectored    = 1'b1;
        present_event();
        @(negedge clk);
        n_checks++;
        if (o_flush !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timer_flush: got %b required 1", o_flush);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_trap_vld !== 1'b1 || o_trap_cause !== 64'h8000_0000_0000_0007) begin
            n_fail++;
            $display("[TB] FAIL timer_cause: vld %b cause %h required 1 8000000000000007", o_trap_vld, o_trap_cause);
        end
        n_checks++;
        if (o_trap_epc !== 64'h100 || o_trap_tval !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL timer_epc_tval: epc %h tval %h required 100 0", o_trap_epc, o_trap_tval);
        end
        @(negedge clk);
        n_checks++;
        if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 64'h201C) begin
            n_fail++;
            $display("[TB] FAIL timer_redirect: vld %b pc %h required 1 201c", o_redirect_vld, o_redirect_pc);
        end
        @(negedge clk);
        set_defaults();
    endtask

    task automatic test_irq_gating();
        @(negedge clk);
        i_irq_pending = 16'h0080;
        i_global_ie   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_ie_off: busy %b required 0", o_busy);
        end
        i_global_ie = 1'b1;
        i_irq_allow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_allow_off: busy %b required 0", o_busy);
        end
        set_defaults();
        @(negedge clk);
    endtask

    task automatic test_irq_priority();
        logic [15:0] pend_tab [6] = '{16'h0888, 16'h1004, 16'h0022, 16'h0280, 16'h8200, 16'h0021};
        logic [5:0]  code_tab [6] = '{6'd11, 6'd2, 6'd1, 6'd7, 6'd9, 6'd5};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_irq_pending = pend_tab[k];
            i_tvec        = 64'h2000;
            i_vectored    = 1'b0;
            present_event();
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (o_trap_vld !== 1'b1 || o_trap_cause !== (64'h8000_0000_0000_0000 | 64'(code_tab[k]))) begin
                n_fail++;
                $display("[TB] FAIL irq_prio[%0d]: vld %b cause %h required code %0d", k, o_trap_vld,
                         o_trap_cause, code_tab[k]);
            end
            @(negedge clk);
            n_checks++;
            if (o_redirect_pc !== 64'h2000) begin
                n_fail++;
                $display("[TB] FAIL irq_prio_redir[%0d]: got %h required 2000", k, o_redirect_pc);
            end
            @(negedge clk);
        end
        set_defaults();
    endtask

    task automatic test_simultaneous();
        logic saw_mret;
        saw_mret = 1'b0;
        @(negedge clk);
        i_exc_vld     = 1'b1;
        i_exc_code    = 6'd5;
        i_exc_epc     = 64'h300;
        i_exc_tval    = 64'h11;
        i_mret_vld    = 1'b1;
        i_mepc        = 64'h4444;
        i_irq_pending = 16'h0008;
        i_tvec        = 64'h3000;
        i_vectored    = 1'b1;
        present_event();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            saw_mret = saw_mret | o_mret;
            if (c == 2) begin
                n_checks++;
                if (o_trap_vld !== 1'b1 || o_trap_cause !== 64'h5 || o_trap_epc !== 64'h300) begin
                    n_fail++;
                    $display("[TB] FAIL simul_cause: vld %b cause %h epc %h required 1 5 300", o_trap_vld,
                             o_trap_cause, o_trap_epc);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (o_redirect_pc !== 64'h3000) begin
                    n_fail++;
                    $display("[TB] FAIL simul_redirect: got %h required 3000", o_redirect_pc);
                end
            end
        end
        n_checks++;
        if (saw_mret !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL simul_no_mret: saw_mret %b busy %b required 0 0", saw_mret, o_busy);
        end
        set_defaults();
    endtask

    task automatic test_mret();
        @(negedge clk);
        i_mret_vld = 1'b1;
        i_mepc     = 64'h4444;
        i_tvec     = 64'h9000;
        present_event();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({o_mret, o_trap_vld} !== 2'b10 || o_trap_cause !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL mret_pulse: mret/trap %b cause %h required 10 0", {o_mret, o_trap_vld}, o_trap_cause);
        end
        @(negedge clk);
        n_checks++;
        if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 64'h4444 || o_mret !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mret_redirect: vld %b pc %h mret %b required 1 4444 0", o_redirect_vld,
                     o_redirect_pc, o_mret);
        end
        @(negedge clk);
        set_defaults();
    endtask

    task automatic test_back_to_back_stalls();
        @(negedge clk);
        i_exc_vld  = 1'b1;
        i_exc_code = 6'd13;
        i_exc_epc  = 64'h700;
        i_tvec     = 64'h5000;
        i_drained  = 1'b0;
        present_event();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({o_commit_block, o_busy, o_trap_vld, o_flush, o_redirect_vld} !== 5'b11000) begin
                n_fail++;
                $display("[TB] FAIL drain_stall[%0d]: got %b required 11000", c,
                         {o_commit_block, o_busy, o_trap_vld, o_flush, o_redirect_vld});
            end
        end
        i_drained = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_trap_vld !== 1'b1 || o_trap_cause !== 64'hD) begin
            n_fail++;
            $display("[TB] FAIL drain_release: vld %b cause %h required 1 d", o_trap_vld, o_trap_cause);
        end
        i_redirect_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_redirect_vld !== 1'b1 || o_redirect_pc !== 64'h5000) begin
                n_fail++;
                $display("[TB] FAIL redirect_hold[%0d]: vld %b pc %h required 1 5000", c, o_redirect_vld,
                         o_redirect_pc);
            end
        end
        i_redirect_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_redirect_vld, o_busy} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL redirect_done: got %b required 00", {o_redirect_vld, o_busy});
        end
        set_defaults();
    endtask

    task automatic test_reset_mid_drain();
        logic saw_trap;
        saw_trap = 1'b0;
        @(negedge clk);
        i_exc_vld  = 1'b1;
        i_exc_code = 6'd4;
        i_exc_epc  = 64'h900;
        i_tvec     = 64'h6000;
        i_drained  = 1'b0;
        present_event();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre_drain: busy %b required 1", o_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_commit_block, o_busy, o_flush, o_trap_vld, o_redirect_vld} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got %b required 00000",
                     {o_commit_block, o_busy, o_flush, o_trap_vld, o_redirect_vld});
        end
        i_drained = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            saw_trap = saw_trap | o_trap_vld | o_busy;
        end
        n_checks++;
        if (saw_trap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_no_pulse: activity %b required 0", saw_trap);
        end
        set_defaults();
    endtask

    initial begin
        test_reset();
        test_illegal_instr();
        test_timer_irq_vectored();
        test_irq_gating();
        test_irq_priority();
        test_simultaneous();
        test_mret();
        test_back_to_back_stalls();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
